pkt_bit_tx: RTL and testbench

Serial packet transmitter that drives the `pkt_data_vld` / `first` / `lastbit` bit-stream interface consumed by the packet-protocol checker blocks of this chapter. A host loads a payload word and bit count with a single-cycle start handshake. The block then emits the payload LSB-first, one bit per clock, with framing strobes, and enforces a minimum idle gap between packets. It sits between a stimulus/host side and any receiver or assertion module on the same interface.

---
 rtl/pkt_bit_tx_if.sv | 28 ++
 rtl/pkt_bit_tx.sv | 156 +++++++++++++++
 tb/tb_pkt_bit_tx.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/pkt_bit_tx_if.sv
// Bit-stream packet interface between a host and pkt_bit_tx.
// master: host side (drives the request, observes status and stream).
// slave : transmitter side.
interface pkt_bit_tx_if #(
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned LW      = $clog2(MAX_LEN + 1)
);
  logic               start;
  logic [LW-1:0]      len;
  logic [MAX_LEN-1:0] data;
  logic               ready;
  logic               len_err;
  logic               pkt_data_vld;
  logic               dout;
  logic               first;
  logic               lastbit;
  logic               done;

  modport master (
    output start, len, data,
    input  ready, len_err, pkt_data_vld, dout, first, lastbit, done
  );

  modport slave (
    input  start, len, data,
    output ready, len_err, pkt_data_vld, dout, first, lastbit, done
  );
endinterface

// File: rtl/pkt_bit_tx.sv
// Serial packet transmitter: sends a latched payload LSB-first, one bit per clock,
// with first/lastbit framing, a done pulse and an enforced idle gap.
// Optional feature: define PKT_TX_PARITY_EN to append an even-parity beat.
module pkt_bit_tx #(
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned GAP     = 3,
  parameter int unsigned LW      = $clog2(MAX_LEN + 1)
) (
  input logic         clk,
  input logic         rst,
  pkt_bit_tx_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

  // Gap counter holds remaining extra gap cycles after the first one.
  localparam logic [3:0] GapLoad = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

`ifdef PKT_TX_PARITY_EN
  localparam logic [LW-1:0] ParBeats = LW'(1);
`else
  localparam logic [LW-1:0] ParBeats = LW'(0);
`endif

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] sh_q, sh_d;
  logic [LW-1:0]      cnt_q, cnt_d;   // beats still to send after the current one
  logic [3:0]         gap_q, gap_d;
  logic               vld_q, vld_d;
  logic               dout_q, dout_d;
  logic               first_q, first_d;
  logic               last_q, last_d;
  logic               done_q, done_d;
  logic               len_err_q, len_err_d;
`ifdef PKT_TX_PARITY_EN
  logic               par_q, par_d;   // running XOR of payload bits already sent
`endif

  logic len_ok;
  assign len_ok = (bus.len != '0) && (bus.len <= LW'(MAX_LEN));

  // Next-state and registered-output decode; stream outputs default to idle.
  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    vld_d     = 1'b0;
    dout_d    = 1'b0;
    first_d   = 1'b0;
    last_d    = 1'b0;
    done_d    = 1'b0;
    len_err_d = 1'b0;
`ifdef PKT_TX_PARITY_EN
    par_d     = par_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (len_ok) begin
            state_d = StSend;
            vld_d   = 1'b1;
            first_d = 1'b1;
            dout_d  = bus.data[0];
            sh_d    = bus.data >> 1;
            cnt_d   = bus.len - LW'(1) + ParBeats;
            last_d  = (cnt_d == '0);
`ifdef PKT_TX_PARITY_EN
            par_d   = bus.data[0];
`endif
          end else begin
            len_err_d = 1'b1;
          end
        end
      end
      StSend: begin
        if (cnt_q != '0) begin
          vld_d  = 1'b1;
          cnt_d  = cnt_q - LW'(1);
          last_d = (cnt_d == '0);
`ifdef PKT_TX_PARITY_EN
          if (cnt_q == LW'(1)) begin
            dout_d = par_q;
          end else begin
            dout_d = sh_q[0];
            sh_d   = sh_q >> 1;
            par_d  = par_q ^ sh_q[0];
          end
`else
          dout_d = sh_q[0];
          sh_d   = sh_q >> 1;
`endif
        end else begin
          // Final beat is on the wire this cycle.
          done_d = 1'b1;
          if (GAP == 0) begin
            state_d = StIdle;
          end else begin
            state_d = StGap;
            gap_d   = GapLoad;
          end
        end
      end
      StGap: begin
        if (gap_q == '0) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      sh_q      <= '0;
      cnt_q     <= '0;
      gap_q     <= '0;
      vld_q     <= 1'b0;
      dout_q    <= 1'b0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
      len_err_q <= 1'b0;
`ifdef PKT_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      vld_q     <= vld_d;
      dout_q    <= dout_d;
      first_q   <= first_d;
      last_q    <= last_d;
      done_q    <= done_d;
      len_err_q <= len_err_d;
`ifdef PKT_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  assign bus.ready        = (state_q == StIdle);
  assign bus.len_err      = len_err_q;
  assign bus.pkt_data_vld = vld_q;
  assign bus.dout         = dout_q;
  assign bus.first        = first_q;
  assign bus.lastbit      = last_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_pkt_bit_tx.sv
// Self-checking bench for pkt_bit_tx: a per-cycle expected-output schedule is built
// from each accepted request and compared against the DUT every cycle.
module tb_pkt_bit_tx;

  localparam int unsigned MAX_LEN = 16;
  localparam int unsigned GAP     = 3;
  localparam int unsigned LW      = $clog2(MAX_LEN + 1);
  localparam int          NCYC    = 4096;
`ifdef PKT_TX_PARITY_EN
  localparam int          PB      = 1;
`else
  localparam int          PB      = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pkt_bit_tx_if #(.MAX_LEN(MAX_LEN), .LW(LW)) bus ();

  pkt_bit_tx #(.MAX_LEN(MAX_LEN), .GAP(GAP), .LW(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Expected outputs indexed by cycle number.
  bit e_vld   [NCYC];
  bit e_dout  [NCYC];
  bit e_first [NCYC];
  bit e_last  [NCYC];
  bit e_done  [NCYC];
  bit e_lerr  [NCYC];
  int idle_from = 0;
  int cyc       = 0;
  bit chk_en    = 1'b0;
  int errors    = 0;
  int checks    = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  // Reference: a legal accepted request at cycle c schedules beats c+1..c+T,
  // done at c+T+1 and readiness from c+T+1+GAP.
  task automatic model(input logic st, input logic [LW-1:0] ln, input logic [MAX_LEN-1:0] d,
                       input logic r);
    int t;
    bit par;
    if (r) begin
      for (int i = cyc + 1; i < NCYC; i++) begin
        e_vld[i] = 0; e_dout[i] = 0; e_first[i] = 0;
        e_last[i] = 0; e_done[i] = 0; e_lerr[i] = 0;
      end
      idle_from = cyc + 1;
    end else if (st && cyc >= idle_from) begin
      if (int'(ln) >= 1 && int'(ln) <= int'(MAX_LEN)) begin
        t   = int'(ln) + PB;
        par = 0;
        for (int k = 1; k <= int'(ln); k++) begin
          e_vld[cyc + k]  = 1;
          e_dout[cyc + k] = d[k-1];
          par = par ^ d[k-1];
        end
        if (PB == 1) begin
          e_vld[cyc + t]  = 1;
          e_dout[cyc + t] = par;
        end
        e_first[cyc + 1]    = 1;
        e_last[cyc + t]     = 1;
        e_done[cyc + t + 1] = 1;
        idle_from = cyc + t + 1 + GAP;
      end else begin
        e_lerr[cyc + 1] = 1;
      end
    end
  endtask

  // One clock cycle: check this cycle's outputs, apply inputs, advance.
  task automatic step(input logic st, input logic [LW-1:0] ln, input logic [MAX_LEN-1:0] d,
                      input logic r);
    @(negedge clk);
    if (chk_en) begin
      check_eq("ready",        bus.ready,        (cyc >= idle_from) ? 1 : 0);
      check_eq("len_err",      bus.len_err,      e_lerr[cyc]);
      check_eq("pkt_data_vld", bus.pkt_data_vld, e_vld[cyc]);
      check_eq("dout",         bus.dout,         e_dout[cyc]);
      check_eq("first",        bus.first,        e_first[cyc]);
      check_eq("lastbit",      bus.lastbit,      e_last[cyc]);
      check_eq("done",         bus.done,         e_done[cyc]);
    end
    bus.start = st;
    bus.len   = ln;
    bus.data  = d;
    rst       = r;
    model(st, ln, d, r);
    @(posedge clk);
    cyc++;
    chk_en = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, LW'($urandom), MAX_LEN'($urandom), 1'b0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.len   = '0;
    bus.data  = '0;
    // Reset held with start asserted, then quiet idle.
    for (int i = 0; i < 3; i++) step(1'b1, LW'(4), 16'h000B, 1'b1);
    idle(3);
    // Nominal, single-bit and maximum-length packets.
    step(1'b1, LW'(4), 16'h000B, 1'b0);
    idle(10);
    step(1'b1, LW'(1), 16'h0001, 1'b0);
    idle(6);
    step(1'b1, LW'(16), 16'hA5C3, 1'b0);
    idle(22);
    // Illegal lengths.
    step(1'b1, LW'(0), 16'hFFFF, 1'b0);
    idle(2);
    step(1'b1, LW'(17), 16'hFFFF, 1'b0);
    idle(2);
    // Requests while busy are ignored; continuous start re-accepts once ready.
    step(1'b1, LW'(6), 16'h002D, 1'b0);
    for (int i = 0; i < 14; i++) step(1'b1, LW'(5), MAX_LEN'($urandom), 1'b0);
    idle(12);
    // Reset during beat 3 of an 8-bit packet, then a fresh packet.
    step(1'b1, LW'(8), 16'h00F5, 1'b0);
    idle(2);
    step(1'b0, LW'(0), 16'h0000, 1'b1);
    idle(3);
    step(1'b1, LW'(5), 16'h0016, 1'b0);
    idle(12);
    // Parity-relevant pattern (plain 3-bit packet in the default build).
    step(1'b1, LW'(3), 16'h0007, 1'b0);
    idle(10);
    // Randomized traffic with occasional illegal lengths and resets.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 2) == 0), LW'($urandom_range(0, 17)), MAX_LEN'($urandom),
           ($urandom_range(0, 63) == 0));
    end
    idle(30);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
